// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone adder issue/collect slice: default widths,
// adder latency and the result record carried from adder to consumer.
package ks_pkg;
  localparam int KS_FBW   = 32;
  localparam int KS_LAT   = 2;
  localparam int KS_DEPTH = 4;

  typedef struct packed {
    logic [KS_FBW-1:0] sum;
    logic              cout;
  } ks_res_t;
endpackage

// File: rtl/ks_res_fifo.sv
// Result FIFO: DEPTH entries of type T, power-of-2 depth, wrapping pointers.
// Storage is not reset; the read port shows zero whenever the FIFO is empty.
module ks_res_fifo
  import ks_pkg::*;
#(
  parameter type T     = ks_res_t,
  parameter int  DEPTH = KS_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          push,
  input  T              wr_data,
  input  logic          pop,
  output T              rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ks_add_issue_ctrl.sv
// Issue/collect stage for the pipelined Kogge-Stone adder with credit-based issue.
// Optional KS_ISSUE_STATS_EN adds saturating issue/stall counters.
module ks_add_issue_ctrl
  import ks_pkg::*;
#(
  parameter int FBW   = KS_FBW,
  parameter int LAT   = KS_LAT,
  parameter int DEPTH = KS_DEPTH
) (
  input  logic           CLK,
  input  logic           RESETn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [FBW-1:0] in_a,
  input  logic [FBW-1:0] in_b,
  input  logic           in_cin,
  output logic [FBW-1:0] add_a,
  output logic [FBW-1:0] add_b,
  output logic           add_cin,
  input  logic [FBW-1:0] add_sum,
  input  logic           add_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [FBW-1:0] out_sum,
  output logic           out_cout
`ifdef KS_ISSUE_STATS_EN
  ,
  output logic [31:0]    stat_issued,
  output logic [31:0]    stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(2 * DEPTH + 1);

  typedef struct packed {
    logic [FBW-1:0] sum;
    logic           cout;
  } res_t;

  logic           issue;
  logic           push;
  logic           pop;
  logic [LAT:1]   vld;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic [OW-1:0]  occ;
  res_t           wr_res;
  res_t           rd_res;

  // Credit: every op in the adder already owns a FIFO slot, so in_ready is purely registered state.
  always_comb begin
    occ = OW'(fifo_count);
    for (int k = 1; k <= LAT; k++) occ = occ + OW'(vld[k]);
  end

  assign in_ready = (occ < OW'(DEPTH));
  assign issue    = in_valid & in_ready;
  assign add_a    = issue ? in_a   : '0;
  assign add_b    = issue ? in_b   : '0;
  assign add_cin  = issue ? in_cin : 1'b0;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld <= '0;
    end else begin
      vld[1] <= issue;
      for (int k = 2; k <= LAT; k++) vld[k] <= vld[k-1];
    end
  end

  // Adder output boundary: result captured the cycle it leaves the last adder stage.
  assign push   = vld[LAT];
  assign wr_res = '{sum: add_sum, cout: add_cout};
  assign pop    = out_valid & out_ready;

  ks_res_fifo #(
    .T     (res_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .push    (push),
    .wr_data (wr_res),
    .pop     (pop),
    .rd_data (rd_res),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_sum   = rd_res.sum;
  assign out_cout  = rd_res.cout;

  a_no_push_full : assert property (@(posedge CLK) disable iff (!RESETn) !(push && fifo_full));

`ifdef KS_ISSUE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue)                 stat_issued <= sat_inc(stat_issued);
      if (in_valid && !in_ready) stat_stall  <= sat_inc(stat_stall);
    end
  end
`endif

endmodule
